stepper_pulse_gen: RTL
======================

// Module: stepper_pulse_gen
// PURPOSE
//  Downstream stage of the SCARA controller: takes one per-move command (steps1/steps2 counts, dir1/dir2)
//  and converts it into STEP/DIR pulse trains for the two joint stepper drivers.
//  Drives stepperReady back to the controller; it is high only when the block can accept a new move.
//  One command = one coordinated move of both joints; the command is latched and inputs may change afterwards.
// PARAMETERS
//  STEP_PERIOD  10  clocks per step slot (pulse + gap); must be >= PULSE_WIDTH+1
//  PULSE_WIDTH  3   clocks a STEP output is held high within a slot; >= 1
//  DIR_SETUP    2   clocks DIR outputs are stable before the first STEP edge; >= 1
// PORTS
//  clk           in   1  system clock
//  reset         in   1  synchronous, active-high reset
//  stepsValid    in   1  command strobe (controller dataReady); accepted on its rising edge
//  steps1        in   8  joint-1 step count, unsigned
//  steps2        in   8  joint-2 step count, unsigned
//  dir1          in   1  joint-1 direction
//  dir2          in   1  joint-2 direction
//  step1         out  1  joint-1 STEP pulse
//  step2         out  1  joint-2 STEP pulse
//  dirOut1       out  1  joint-1 DIR to driver
//  dirOut2       out  1  joint-2 DIR to driver
//  stepperReady  out  1  high = idle, new command can be accepted
// BEHAVIOUR
//  - One clock (clk); reset is synchronous and active-high. Reset values: step1=step2=0, dirOut1=dirOut2=0,
//    stepperReady=1, FSM=IDLE, counters=0, the registered copy of stepsValid=0.
//  - Accept: in IDLE, a rising edge of stepsValid (stepsValid=1 and its previous-cycle value=0) latches
//    steps1/2 and dir1/2. stepperReady=0 from the next cycle on. A level held high is accepted only once.
//    Edges seen outside IDLE are dropped; they are not queued.
//  - FSM: IDLE -> SETUP -> RUN -> IDLE.
//  - SETUP: dirOut1/2 take the latched directions on the cycle after acceptance and stay constant for
//    DIR_SETUP cycles. No STEP pulses are issued in SETUP.
//  - RUN: N = max(steps1,steps2) slots, each STEP_PERIOD clocks long. Within a slot, a pulsing axis has its
//    STEP high for the first PULSE_WIDTH clocks and low for the rest. Slot counter and per-axis remaining
//    counts update at the last clock of each slot. After slot N-1 ends: IDLE, stepperReady=1 next cycle.
//  - Zero move (steps1=steps2=0): SETUP and RUN are skipped. IDLE is re-entered and stepperReady=1
//    two cycles after the accepting edge. No pulses are issued and dirOut is unchanged.
//  - Per-axis pulse choice with the macro off: axis i pulses in slot k iff k < steps_i. Both axes start together.
//  - Latency (non-zero move): first STEP rise at acceptance + 1 + DIR_SETUP cycles.
//    stepperReady=1 at acceptance + 1 + DIR_SETUP + N*STEP_PERIOD + 1.
//  - Reset mid-move: at the next edge the move is abandoned, all outputs go to reset values and STEP falls.
//  - Widths: remaining counts 8 bits and never decremented below 0. Slot clock counter is
//    $clog2(STEP_PERIOD) bits and wraps to 0 at STEP_PERIOD-1.
// CONFIGURATION
//  SCARA_STEP_SYNC_AXES_EN defined: Bresenham coordination so both joints finish together.
//    Major axis (larger count; axis 1 on a tie) pulses every slot. Minor axis pulses in slot k iff
//    floor((k+1)*minor/major) > floor(k*minor/major). Implemented with a 9-bit error accumulator.
//  SCARA_STEP_SYNC_AXES_EN undefined: independent front-loaded stepping as described above.
//  Slot count N and all latencies are identical in both builds.
// STRUCTURE
//  Package scara_stepper_pkg: enum stepper_state_t {IDLE,SETUP,RUN}; localparam STEP_CNT_W=8.
//  Sub-module stepper_axis: holds one axis's latched count/remaining counter. Decides pulse-in-slot
//    (including the Bresenham accumulator under the macro) and drives STEP. Instantiated twice.
//  Top level owns the FSM, edge detect, slot/clock counters, the DIR registers and stepperReady.
// TESTING (STEP_PERIOD=10, PULSE_WIDTH=3, DIR_SETUP=2)
//  1 Reset asserted mid-idle with stepsValid=1 -> step1/2=0, dirOut1/2=0, stepperReady=1. No acceptance
//    until stepsValid falls and then rises again.
//  2 steps1=3, steps2=1, dir1=1, dir2=0 (macro off) -> dirOut1=1 at t+1; step1 rises at t+3, t+13, t+23,
//    each high 3 clocks; step2 rises only at t+3; stepperReady=1 at t+34.
//  3 Same with steps1=4, steps2=2 and SCARA_STEP_SYNC_AXES_EN -> step1 pulses in slots 0-3; step2 pulses in
//    slots 1 and 3 only (rising at t+13, t+33); stepperReady=1 at t+44.
//  4 steps1=steps2=0 -> no STEP pulses; dirOut unchanged; stepperReady low for exactly 1 cycle (t+1), high at t+2.
//  5 stepsValid held high 5 cycles, then re-pulsed during RUN with new counts -> exactly one move executed
//    with the original counts; the re-pulse is ignored.
//  6 reset asserted during the second slot while step1=1 -> next edge: step1=0, stepperReady=1, FSM=IDLE.
//    A fresh command then executes normally.

Source files
------------

// File: rtl/scara_stepper_pkg.sv
// Shared types and widths for the SCARA two-joint STEP/DIR pulse generator.
package scara_stepper_pkg;

  localparam int STEP_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    RUN
  } stepper_state_t;

  function automatic logic [STEP_CNT_W-1:0] max_cnt(input logic [STEP_CNT_W-1:0] a,
                                                    input logic [STEP_CNT_W-1:0] b);
    return (a >= b) ? a : b;
  endfunction

endpackage

// File: rtl/stepper_axis.sv
// One joint's STEP generator: latched count, remaining-step counter and per-slot pulse decision.
// SCARA_STEP_SYNC_AXES_EN selects Bresenham spacing against the major-axis count instead of front-loading.
module stepper_axis
  import scara_stepper_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [STEP_CNT_W-1:0] steps,
`ifdef SCARA_STEP_SYNC_AXES_EN
  input  logic [STEP_CNT_W-1:0] major,
`endif
  input  logic                  run,
  input  logic                  slot_end,
  input  logic                  pulse_win,
  output logic                  step
);

  logic [STEP_CNT_W-1:0] rem_q, rem_d;
  logic                  fire;
`ifdef SCARA_STEP_SYNC_AXES_EN
  logic [STEP_CNT_W-1:0] cnt_q, cnt_d;
  logic [STEP_CNT_W:0]   acc_q, acc_d, acc_sum;
`endif

  // fire depends only on state that changes at slot boundaries, so it is stable for a whole slot
  always_comb begin
    rem_d = rem_q;
`ifdef SCARA_STEP_SYNC_AXES_EN
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    acc_sum = acc_q + {1'b0, cnt_q};
    fire    = (rem_q != '0) && (acc_sum >= {1'b0, major});
`else
    fire    = (rem_q != '0);
`endif
    if (load) begin
      rem_d = steps;
`ifdef SCARA_STEP_SYNC_AXES_EN
      cnt_d = steps;
      acc_d = '0;
`endif
    end else if (run && slot_end) begin
      if (fire) rem_d = rem_q - STEP_CNT_W'(1);
`ifdef SCARA_STEP_SYNC_AXES_EN
      acc_d = fire ? (acc_sum - {1'b0, major}) : acc_sum;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q <= '0;
`ifdef SCARA_STEP_SYNC_AXES_EN
      cnt_q <= '0;
      acc_q <= '0;
`endif
    end else begin
      rem_q <= rem_d;
`ifdef SCARA_STEP_SYNC_AXES_EN
      cnt_q <= cnt_d;
      acc_q <= acc_d;
`endif
    end
  end

  assign step = run && pulse_win && fire;

endmodule

// File: rtl/stepper_pulse_gen.sv
// Converts one latched two-joint move command into STEP/DIR pulse trains; owns FSM, slot timing and DIR.
// Build option SCARA_STEP_SYNC_AXES_EN: Bresenham-coordinated axes (same slot count and latencies).
module stepper_pulse_gen
  import scara_stepper_pkg::*;
#(
  parameter int STEP_PERIOD = 10,
  parameter int PULSE_WIDTH = 3,
  parameter int DIR_SETUP   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stepsValid,
  input  logic [STEP_CNT_W-1:0] steps1,
  input  logic [STEP_CNT_W-1:0] steps2,
  input  logic                  dir1,
  input  logic                  dir2,
  output logic                  step1,
  output logic                  step2,
  output logic                  dirOut1,
  output logic                  dirOut2,
  output logic                  stepperReady
);

  localparam int CLK_CNT_W   = $clog2(STEP_PERIOD);
  localparam int SETUP_CNT_W = (DIR_SETUP > 1) ? $clog2(DIR_SETUP) : 1;
  localparam logic [CLK_CNT_W-1:0]   SLOT_LAST  = CLK_CNT_W'(STEP_PERIOD - 1);
  localparam logic [CLK_CNT_W-1:0]   PW         = CLK_CNT_W'(PULSE_WIDTH);
  localparam logic [SETUP_CNT_W-1:0] SETUP_LAST = SETUP_CNT_W'(DIR_SETUP - 1);

  stepper_state_t          state_q, state_d;
  logic                    valid_q, valid_d;
  logic                    armed_q, armed_d;
  logic                    ready_q, ready_d;
  logic                    dir1_q, dir1_d, dir2_q, dir2_d;
  logic [SETUP_CNT_W-1:0]  setup_cnt_q, setup_cnt_d;
  logic [CLK_CNT_W-1:0]    clk_cnt_q, clk_cnt_d;
  logic [STEP_CNT_W-1:0]   slot_q, slot_d;
  logic [STEP_CNT_W-1:0]   n_q, n_d;
  logic [STEP_CNT_W-1:0]   n_in;
  logic                    accept, run, slot_end, pulse_win;

  always_comb begin
    n_in      = max_cnt(steps1, steps2);
    run       = (state_q == RUN);
    slot_end  = run && (clk_cnt_q == SLOT_LAST);
    pulse_win = (clk_cnt_q < PW);
    // armed_q blocks a level that was already high when reset released from counting as an edge
    accept    = (state_q == IDLE) && stepsValid && !valid_q && armed_q;

    state_d     = state_q;
    valid_d     = stepsValid;
    armed_d     = armed_q | ~stepsValid;
    ready_d     = (state_q == IDLE) && !accept;
    dir1_d      = dir1_q;
    dir2_d      = dir2_q;
    setup_cnt_d = setup_cnt_q;
    clk_cnt_d   = clk_cnt_q;
    slot_d      = slot_q;
    n_d         = n_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          n_d = n_in;
          if (n_in != '0) begin
            state_d     = SETUP;
            dir1_d      = dir1;
            dir2_d      = dir2;
            setup_cnt_d = '0;
          end
        end
      end
      SETUP: begin
        if (setup_cnt_q == SETUP_LAST) begin
          state_d   = RUN;
          clk_cnt_d = '0;
          slot_d    = '0;
        end else begin
          setup_cnt_d = setup_cnt_q + SETUP_CNT_W'(1);
        end
      end
      RUN: begin
        if (slot_end) begin
          clk_cnt_d = '0;
          slot_d    = slot_q + STEP_CNT_W'(1);
          if (slot_q == n_q - STEP_CNT_W'(1)) state_d = IDLE;
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      valid_q     <= 1'b0;
      armed_q     <= 1'b0;
      ready_q     <= 1'b1;
      dir1_q      <= 1'b0;
      dir2_q      <= 1'b0;
      setup_cnt_q <= '0;
      clk_cnt_q   <= '0;
      slot_q      <= '0;
      n_q         <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      armed_q     <= armed_d;
      ready_q     <= ready_d;
      dir1_q      <= dir1_d;
      dir2_q      <= dir2_d;
      setup_cnt_q <= setup_cnt_d;
      clk_cnt_q   <= clk_cnt_d;
      slot_q      <= slot_d;
      n_q         <= n_d;
    end
  end

  stepper_axis u_axis1 (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .steps     (steps1),
`ifdef SCARA_STEP_SYNC_AXES_EN
    .major     (n_q),
`endif
    .run       (run),
    .slot_end  (slot_end),
    .pulse_win (pulse_win),
    .step      (step1)
  );

  stepper_axis u_axis2 (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .steps     (steps2),
`ifdef SCARA_STEP_SYNC_AXES_EN
    .major     (n_q),
`endif
    .run       (run),
    .slot_end  (slot_end),
    .pulse_win (pulse_win),
    .step      (step2)
  );

  assign dirOut1      = dir1_q;
  assign dirOut2      = dir2_q;
  assign stepperReady = ready_q;

endmodule
